// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU core: sequencer states and address defaults.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        IND_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam logic [7:0]  DEF_RESET_PC = 8'h00;

endpackage : cpu_pkg

// File: rtl/dmem_timeout_ctr.sv
// 8-bit wait counter for indirect-jump reads; tc flags the last cycle before the limit.
module dmem_timeout_ctr #(
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_LAST = 8'(TERMINAL - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // Asserted while the next increment would reach TERMINAL.
    assign tc = (count == TC_LAST);

endmodule : dmem_timeout_ctr

// File: rtl/pc_jump_sequencer.sv
// PC controller: drives the external jump_address_mux and reloads the PC from its output.
module pc_jump_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]     RESET_PC     = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned           DMEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step_en,
    input  logic              halt_req,
    input  logic              jump_req,
    input  logic              cond_req,
    input  logic              branch_cond,
    input  logic              ind_jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              resume,
    input  logic [ADDR_W-1:0] dmem_rdata,
    input  logic              dmem_valid,
    input  logic [ADDR_W-1:0] mux_address,
    output logic              address_ctl,
    output logic [ADDR_W-1:0] address_in,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_raddr,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              halted,
    output logic              err
);

    state_t            state;
    state_t            state_nx;
    logic              pc_load;
    logic              ind_start;
    logic              set_err;
    logic              ctr_en;
    logic              timeout;
    logic [ADDR_W-1:0] pc_inc;

    // Read data reaches the PC only through the external mux.
    logic unused_rdata;
    assign unused_rdata = ^dmem_rdata;

    assign pc_inc = pc + ADDR_W'(1);
    assign ctr_en = (state == IND_WAIT) && !dmem_valid;

    dmem_timeout_ctr #(
        .TERMINAL (DMEM_TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ind_start),
        .en    (ctr_en),
        .tc    (timeout)
    );

    always_comb begin
        state_nx    = state;
        address_ctl = 1'b0;
        address_in  = pc_inc;
        pc_load     = 1'b0;
        ind_start   = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                if (step_en) begin
                    if (halt_req) begin
                        state_nx = HALT;
                    end else if (ind_jump_req) begin
                        ind_start = 1'b1;
                        state_nx  = IND_WAIT;
                    end else begin
                        if (jump_req || (cond_req && branch_cond)) address_in = jump_target;
                        pc_load = 1'b1;
                    end
                end
            end
            IND_WAIT: begin
                address_ctl = 1'b1;
                if (dmem_valid) begin
                    pc_load  = 1'b1;
                    state_nx = FETCH;
                end else if (timeout) begin
                    set_err  = 1'b1;
                    state_nx = HALT;
                end
            end
            HALT: begin
                if (resume) begin
                    pc_load  = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            err        <= 1'b0;
            dmem_re    <= 1'b0;
            dmem_raddr <= '0;
        end else begin
            state   <= state_nx;
            dmem_re <= ind_start;
            if (pc_load)   pc         <= mux_address;
            if (set_err)   err        <= 1'b1;
            if (ind_start) dmem_raddr <= jump_target;
        end
    end

    assign fetch_valid = (state == FETCH);
    assign halted      = (state == HALT);

endmodule : pc_jump_sequencer

// File: tb/tb_pc_jump_sequencer.sv
// Scoreboard bench for pc_jump_sequencer with a behavioural jump_address_mux.
module tb_pc_jump_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, step_en, halt_req, jump_req, cond_req, branch_cond;
    logic       ind_jump_req, resume, dmem_valid;
    logic [7:0] jump_target, dmem_rdata, mux_address;
    logic       address_ctl, dmem_re, fetch_valid, halted, err;
    logic [7:0] address_in, dmem_raddr, pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic       fv;
        logic       hlt;
        logic       er;
        logic       actl;
        bit         full;
        logic [7:0] ain;
        logic       re;
        logic [7:0] raddr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] re_q[$];

    always #5 clk = ~clk;

    assign mux_address = address_ctl ? dmem_rdata : address_in;

    pc_jump_sequencer #(
        .ADDR_W       (8),
        .RESET_PC     (8'h00),
        .DMEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .step_en      (step_en),
        .halt_req     (halt_req),
        .jump_req     (jump_req),
        .cond_req     (cond_req),
        .branch_cond  (branch_cond),
        .ind_jump_req (ind_jump_req),
        .jump_target  (jump_target),
        .resume       (resume),
        .dmem_rdata   (dmem_rdata),
        .dmem_valid   (dmem_valid),
        .mux_address  (mux_address),
        .address_ctl  (address_ctl),
        .address_in   (address_in),
        .dmem_re      (dmem_re),
        .dmem_raddr   (dmem_raddr),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .err          (err)
    );

    // State monitor: one queued expectation consumed per falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            ok = (pc === e.pc) && (fetch_valid === e.fv) && (halted === e.hlt) &&
                 (err === e.er) && (address_ctl === e.actl);
            if (e.full)
                ok = ok && (address_in === e.ain) && (dmem_re === e.re) && (dmem_raddr === e.raddr);
            if (!ok) begin
                bad++;
                $display("FAIL %s: got pc=%h fv=%b halted=%b err=%b actl=%b ain=%h re=%b raddr=%h; want pc=%h fv=%b halted=%b err=%b actl=%b ain=%h re=%b raddr=%h",
                         e.name, pc, fetch_valid, halted, err, address_ctl, address_in, dmem_re, dmem_raddr,
                         e.pc, e.fv, e.hlt, e.er, e.actl, e.ain, e.re, e.raddr);
            end
        end
    end

    // Read-strobe monitor: every dmem_re cycle must match a queued read address.
    always @(negedge clk) begin
        logic [7:0] a;
        if (dmem_re === 1'b1) begin
            total++;
            if (re_q.size() == 0) begin
                bad++;
                $display("FAIL dmem_re_unexpected: got raddr=%h, want no strobe", dmem_raddr);
            end else begin
                a = re_q.pop_front();
                if (dmem_raddr !== a) begin
                    bad++;
                    $display("FAIL dmem_raddr: got %h, want %h", dmem_raddr, a);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] p, input logic fv, input logic h,
                       input logic er, input logic ac);
        exp_q.push_back('{n, p, fv, h, er, ac, 1'b0, 8'h00, 1'b0, 8'h00});
    endtask

    task automatic chk_reset(input string n);
        exp_q.push_back('{n, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00});
    endtask

    task automatic clear_req();
        step_en = 0; halt_req = 0; jump_req = 0; cond_req = 0; branch_cond = 0;
        ind_jump_req = 0; resume = 0; start = 0;
    endtask

    // Issue one direct jump step from FETCH.
    task automatic jump_to(input logic [7:0] t);
        step_en = 1; jump_req = 1; jump_target = t;
        tick();
        clear_req();
    endtask

    initial begin
        rst_n = 0; dmem_valid = 0; dmem_rdata = 8'h00; jump_target = 8'h00;
        clear_req();
        tick(); tick();
        chk_reset("reset");
        tick();
        rst_n = 1;
        tick();

        start = 1;
        tick();
        start = 0;
        chk("start", 8'h00, 1, 0, 0, 0);
        tick();
        chk("idle_hold", 8'h00, 1, 0, 0, 0);

        step_en = 1;
        tick(); chk("seq1", 8'h01, 1, 0, 0, 0);
        tick(); chk("seq2", 8'h02, 1, 0, 0, 0);
        tick(); chk("seq3", 8'h03, 1, 0, 0, 0);
        step_en = 0;
        dmem_valid = 1; dmem_rdata = 8'h55;
        tick(); chk("no_step_dvalid_ignored", 8'h03, 1, 0, 0, 0);
        dmem_valid = 0;

        jump_to(8'hFF); chk("jump_ff", 8'hFF, 1, 0, 0, 0);
        step_en = 1;
        tick(); chk("wrap", 8'h00, 1, 0, 0, 0);
        step_en = 0;

        jump_to(8'h05);
        step_en = 1; cond_req = 1; branch_cond = 0; jump_target = 8'h40;
        tick(); clear_req(); chk("cond_not_taken", 8'h06, 1, 0, 0, 0);
        jump_to(8'h05);
        step_en = 1; cond_req = 1; branch_cond = 1; jump_target = 8'h40;
        tick(); clear_req(); chk("cond_taken", 8'h40, 1, 0, 0, 0);
        step_en = 1; halt_req = 1; jump_req = 1; jump_target = 8'h77;
        tick(); clear_req(); chk("halt_over_jump", 8'h40, 0, 1, 0, 0);
        step_en = 1;
        tick(); clear_req(); chk("halt_ignores_step", 8'h40, 0, 1, 0, 0);
        resume = 1;
        tick(); clear_req(); chk("resume", 8'h41, 1, 0, 0, 0);

        // Indirect jump answered three cycles after the strobe.
        re_q.push_back(8'h10);
        step_en = 1; ind_jump_req = 1; jump_target = 8'h10;
        tick(); clear_req(); chk("ind_wait0", 8'h41, 0, 0, 0, 1);
        tick(); chk("ind_wait1", 8'h41, 0, 0, 0, 1);
        tick(); chk("ind_wait2", 8'h41, 0, 0, 0, 1);
        dmem_valid = 1; dmem_rdata = 8'h9A;
        tick(); dmem_valid = 0; chk("ind_done", 8'h9A, 1, 0, 0, 0);

        // Indirect jump never answered: 15 wait cycles then HALT with err.
        re_q.push_back(8'h20);
        step_en = 1; ind_jump_req = 1; jump_target = 8'h20;
        tick(); clear_req();
        for (int i = 1; i < 15; i++) begin
            tick();
            if (i == 1 || i == 14) chk($sformatf("to_wait%0d", i), 8'h9A, 0, 0, 0, 1);
        end
        tick(); chk("timeout_halt", 8'h9A, 0, 1, 1, 0);
        resume = 1;
        tick(); clear_req(); chk("resume_after_err", 8'h9B, 1, 0, 1, 0);

        // Reset in the middle of a wait; a late response must be ignored.
        re_q.push_back(8'h30);
        step_en = 1; ind_jump_req = 1; jump_target = 8'h30;
        tick(); clear_req(); chk("ind_wait_pre_rst", 8'h9B, 0, 0, 1, 1);
        tick();
        rst_n = 0;
        #1;
        chk_reset("reset_mid_wait");
        tick();
        rst_n = 1; dmem_valid = 1; dmem_rdata = 8'h77;
        tick(); dmem_valid = 0;
        chk("late_data_ignored", 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0 || re_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending_state=%0d pending_reads=%0d, want 0 and 0",
                     exp_q.size(), re_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1);
    end

endmodule : tb_pc_jump_sequencer

// File: doc/pc_jump_sequencer.md
# pc_jump_sequencer

Program-counter controller for the 8-bit CPU core. Owns the PC register and sequences the `jump_address_mux` datapath. Each instruction step drives the mux select (`address_ctl`) and the direct address (`address_in`), then loads the mux output back into the PC. Supports sequential advance, direct and conditional jumps, indirect jumps through data memory with a read timeout, and halt/resume.

## Interface
- `ADDR_W`, 8, PC / address width.
- `RESET_PC`, 8'h00, PC value after reset.
- `DMEM_TIMEOUT`, 15, max cycles spent waiting for `dmem_valid` on an indirect jump (1..255).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching.
- `step_en` in 1: decoded instruction fields are valid this cycle; consume one step.
- `halt_req` in 1: current instruction is HALT.
- `jump_req` in 1: unconditional direct jump.
- `cond_req` in 1: conditional direct jump.
- `branch_cond` in 1: condition flag for `cond_req`.
- `ind_jump_req` in 1: indirect jump; target is read from data memory at `jump_target`.
- `jump_target` in ADDR_W: immediate target, or pointer address for an indirect jump.
- `resume` in 1: leave HALT.
- `dmem_rdata` in ADDR_W: data memory read data; drives the mux `data_mem_val` port externally.
- `dmem_valid` in 1: `dmem_rdata` valid.
- `mux_address` in ADDR_W: `address` output of `jump_address_mux`.
- `address_ctl` out 1: mux select. 0 selects `address_in`; 1 selects the data memory value.
- `address_in` out ADDR_W: direct next address to the mux.
- `dmem_re` out 1: one-cycle read strobe.
- `dmem_raddr` out ADDR_W: read address.
- `pc` out ADDR_W: current PC.
- `fetch_valid` out 1: `pc` is a valid fetch address.
- `halted` out 1: in HALT.
- `err` out 1: sticky indirect-read timeout flag. Cleared only by reset.

## Operation
- States are IDLE, FETCH, IND_WAIT and HALT.
- IDLE:
  - `fetch_valid`=0.
  - `start` moves the block to FETCH.
- FETCH:
  - `fetch_valid`=1.
  - With `step_en`=0, nothing changes.
  - With `step_en`=1, requests are handled in this priority order:
    - `halt_req`: go to HALT. PC unchanged.
    - `ind_jump_req`: pulse `dmem_re`, set `dmem_raddr`=`jump_target`, clear the timeout counter, go to IND_WAIT. PC unchanged.
    - `jump_req`, or `cond_req` with `branch_cond`=1: `address_in`=`jump_target`, `address_ctl`=0, load PC from `mux_address`.
    - Otherwise: `address_in`=`pc`+1 (mod 2^ADDR_W, so 8'hFF wraps to 8'h00), `address_ctl`=0, load PC from `mux_address`.
- IND_WAIT:
  - `address_ctl`=1 and `fetch_valid`=0.
  - `dmem_valid`=1: load PC from `mux_address`, go to FETCH.
  - Otherwise the counter increments. When it reaches DMEM_TIMEOUT: set `err`, go to HALT, PC unchanged.
  - If `dmem_valid` arrives in the same cycle as the timeout, `dmem_valid` wins.
- HALT:
  - `halted`=1 and `fetch_valid`=0.
  - `resume` sets PC to `pc`+1 (through the mux, `address_ctl`=0) and goes to FETCH.
- PC is only ever loaded from `mux_address`. No direct load path bypasses the mux.
- `dmem_valid` is ignored outside IND_WAIT.
- `step_en`, `start` and `resume` are ignored in states where they have no meaning.

## Timing
- Reset values:
  - `pc`=RESET_PC
  - state IDLE
  - `address_ctl`=0
  - `address_in`=RESET_PC+1
  - `dmem_re`=0
  - `dmem_raddr`=0
  - `fetch_valid`=0
  - `halted`=0
  - `err`=0
  - timeout counter 0
- `address_ctl` and `address_in` are combinational from state, `pc` and the decode inputs. `mux_address` must settle within the same cycle.
- `dmem_re` and `dmem_raddr` are registered. `dmem_re` asserts the cycle after the step and lasts exactly one cycle.
- Latencies:
  - Sequential advance and direct jump: PC updates on the clock edge that consumes `step_en`, a latency of 1.
  - Indirect jump: PC updates on the edge where `dmem_valid`=1. Minimum latency is 2 cycles after the step.
- Reset asserted in any state, including mid-IND_WAIT, returns all outputs to their reset values immediately. Any pending read response is discarded.

## Structure
- The shared package `cpu_pkg` holds:
  - the state enum (IDLE, FETCH, IND_WAIT, HALT);
  - the `ADDR_W` default;
  - the `RESET_PC` constant.
- `jump_address_mux` stays external. The sequencer only drives it and reads it back.
- One sub-module, `dmem_timeout_ctr`: an 8-bit counter with clear, enable and terminal-count output.

## Test plan
- Reset, then `start`, then 3 plain steps: `pc` goes 00→01→02→03. `address_ctl`=0 throughout, `fetch_valid`=1 from FETCH on.
- PC=8'hFF, plain step: `pc`=8'h00 (wrap).
- Conditional jump at PC=05 with `jump_target`=8'h40:
  - `branch_cond`=0 gives `pc`=06.
  - `branch_cond`=1 gives `pc`=40.
  - `halt_req`+`jump_req` together gives HALT with `pc` unchanged.
- Indirect jump, `jump_target`=8'h10, `dmem_valid` 3 cycles later with `dmem_rdata`=8'h9A:
  - `dmem_re` pulses once with `dmem_raddr`=10.
  - `address_ctl`=1 during the wait.
  - `pc`=9A, then FETCH.
- Indirect jump with no `dmem_valid`: after DMEM_TIMEOUT (15) cycles `err`=1, `halted`=1, PC unchanged. `resume` gives `pc`+1 and FETCH, with `err` still 1.
- `rst_n` pulsed low mid-IND_WAIT, then a late `dmem_valid`: all outputs at reset values, `pc`=RESET_PC, late data ignored.
